// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between the upstream FIFO wrapper and the serial drain stage.
// The drain stage owns the pop strobe (master); the FIFO supplies empty flag and data (slave).
interface fifo_uart_tx_if #(
    parameter int unsigned BIT_DEPTH = 8
);
    logic                 fifo_empty;
    logic [BIT_DEPTH-1:0] value_to_read;
    logic                 enable_read;

    modport master (
        input  fifo_empty,
        input  value_to_read,
        output enable_read
    );

    modport slave (
        output fifo_empty,
        output value_to_read,
        input  enable_read
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains the upstream FIFO one word at a time and shifts each word out as a
// start / BIT_DEPTH data (LSB first) / stop frame on a UART-style line.
module fifo_uart_tx #(
    parameter int unsigned BIT_DEPTH    = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);
    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
    localparam int unsigned   IW       = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BIT_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [BIT_DEPTH-1:0] r_shift;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_enable_read;
    logic                 w_bit_end;

    assign w_bit_end        = (r_cnt == CNT_LAST);
    assign tx               = r_tx;
    assign busy             = r_busy;
    assign frame_done       = r_frame_done;
    assign fifo.enable_read = r_enable_read;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_enable_read <= 1'b0;
        end else begin
            r_enable_read <= 1'b0;
            r_frame_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!fifo.fifo_empty) begin
                        r_enable_read <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_POP;
                    end
                end
                // FIFO read latency: data appears one clock after the pop edge
                S_POP: r_state <= S_LOAD;
                S_LOAD: begin
                    r_shift <= fifo.value_to_read;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_tx    <= 1'b0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Chain straight into the next pop so busy never drops between frames
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt        <= '0;
                        r_frame_done <= 1'b1;
                        if (!fifo.fifo_empty) begin
                            r_enable_read <= 1'b1;
                            r_state       <= S_POP;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised scoreboard bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT,
// and a line monitor decodes every frame against the words queued by the stimulus.
module tb_fifo_uart_tx;
    localparam int unsigned BD    = 8;
    localparam int unsigned CPB   = 4;
    localparam int          FRAME = (BD + 2) * CPB;

    logic clk = 1'b0;
    logic rst;
    logic tx, busy, frame_done;

    always #5 clk = ~clk;

    fifo_uart_tx_if #(.BIT_DEPTH(BD)) ifc ();

    fifo_uart_tx #(
        .BIT_DEPTH   (BD),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo      (ifc),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: words pushed by stimulus, popped on the DUT strobe, data valid one clock later
    logic [BD-1:0] fifo_q[$];
    logic [BD-1:0] exp_q[$];
    logic [BD-1:0] rd_data     = '0;
    logic          model_empty = 1'b1;
    logic          force_empty = 1'b0;
    int            pops        = 0;
    int            pushed      = 0;

    assign ifc.fifo_empty    = model_empty | force_empty;
    assign ifc.value_to_read = rd_data;

    always @(posedge clk) begin
        if (ifc.enable_read) begin
            checks++;
            pops++;
            if (fifo_q.size() == 0) begin
                failures++;
                $display("FAIL pop_underflow: enable_read with %0d words held, required >0", fifo_q.size());
            end else begin
                rd_data <= fifo_q.pop_front();
            end
            model_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic push(input logic [BD-1:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        model_empty = 1'b0;
        pushed++;
    endtask

    // Line monitor
    int            starts         = 0;
    int            frames_done    = 0;
    int            b2b_done       = 0;
    int            last_pop_cyc   = -1000;
    int            last_start_cyc = 0;
    int            prev_start     = 0;
    logic          have_prev      = 1'b0;
    logic          busy_low       = 1'b1;
    logic          prev_tx        = 1'b1;
    logic          has_exp, aborted, busy_bad, extra_pop;
    logic [BD-1:0] exp_b;
    logic [BD+1:0] exp_line;
    logic [FRAME-1:0] line_s, exp_s;
    logic [2:0]    fd;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_tx  = 1'b1;
                busy_low = 1'b1;
                continue;
            end
            if (ifc.enable_read) last_pop_cyc = cyc;
            if (!busy) busy_low = 1'b1;
            if (prev_tx && !tx) begin
                starts++;
                last_start_cyc = cyc;
                checks++;
                if (cyc - last_pop_cyc != 2) begin
                    failures++;
                    $display("FAIL pop_to_start: latency %0d clocks, required 2", cyc - last_pop_cyc);
                end
                if (have_prev && !busy_low) begin
                    checks++;
                    b2b_done++;
                    if (cyc - prev_start != FRAME + 2) begin
                        failures++;
                        $display("FAIL start_spacing: %0d clocks, required %0d", cyc - prev_start, FRAME + 2);
                    end
                end
                have_prev  = 1'b1;
                prev_start = cyc;
                busy_low   = 1'b0;
                has_exp    = 1'b1;
                exp_b      = '0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    has_exp = 1'b0;
                    $display("FAIL unexpected_frame: frame started with 0 words outstanding, required >=1");
                end else begin
                    exp_b = exp_q.pop_front();
                end
                exp_line = {1'b1, exp_b, 1'b0};
                for (int i = 0; i < FRAME; i++) exp_s[i] = exp_line[i / CPB];
                line_s    = '0;
                line_s[0] = tx;
                busy_bad  = 1'b0;
                extra_pop = 1'b0;
                aborted   = 1'b0;
                fd        = '0;
                for (int k = 1; k <= FRAME + 1; k++) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (ifc.enable_read) begin
                        if (k < FRAME) extra_pop = 1'b1;
                        last_pop_cyc = cyc;
                    end
                    if (!busy) begin
                        if (k < FRAME) busy_bad = 1'b1;
                        busy_low = 1'b1;
                    end
                    if (k < FRAME) line_s[k] = tx;
                    if (k >= FRAME - 1) fd[k - (FRAME - 1)] = frame_done;
                end
                frames_done++;
                if (aborted) begin
                    busy_low = 1'b1;
                end else if (has_exp) begin
                    checks++;
                    if (line_s !== exp_s) begin
                        failures++;
                        $display("FAIL frame_line: got %h, required %h (word %h)", line_s, exp_s, exp_b);
                    end
                    checks++;
                    if (fd !== 3'b010) begin
                        failures++;
                        $display("FAIL frame_done_pulse: got %b around stop end, required 010", fd);
                    end
                    checks++;
                    if (busy_bad || extra_pop) begin
                        failures++;
                        $display("FAIL in_frame_ctrl: busy_dropped=%b extra_pop=%b, required 0 0", busy_bad, extra_pop);
                    end
                end
            end
            prev_tx = tx;
        end
    end

    int target = 0;

    task automatic wait_frames(input int tgt);
        int n;
        n = 0;
        while (frames_done < tgt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frames_done < tgt) begin
            failures++;
            $display("FAIL wait_frames: %0d frames seen, required %0d", frames_done, tgt);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || ifc.enable_read !== 1'b0) begin
            failures++;
            $display("FAIL %s: tx=%b busy=%b enable_read=%b, required 1 0 0", name, tx, busy, ifc.enable_read);
        end
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 30000 clocks");
        $fatal(1, "watchdog");
    end

    int p0, s0, n, bad, push_e0;
    logic [BD-1:0] rv;

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || ifc.enable_read !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: tx=%b er=%b busy=%b fd=%b, required 1 0 0 0",
                     tx, ifc.enable_read, busy, frame_done);
        end
        rst = 1'b1;

        // reset idle with empty FIFO
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || ifc.enable_read !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_idle: %0d bad cycles, required 0", bad);
        end

        // single word
        p0 = pops;
        push(8'hA5);
        target += 1;
        wait_frames(target);
        checks++;
        if (pops - p0 != 1) begin
            failures++;
            $display("FAIL single_pops: %0d pops, required 1", pops - p0);
        end
        check_idle("single_idle_after");

        // drain 0..8 back to back
        p0 = pops;
        s0 = b2b_done;
        for (int i = 0; i < 9; i++) push(BD'(i));
        target += 9;
        wait_frames(target);
        checks++;
        if (pops - p0 != 9) begin
            failures++;
            $display("FAIL drain_pops: %0d pops, required 9", pops - p0);
        end
        checks++;
        if (b2b_done - s0 != 8) begin
            failures++;
            $display("FAIL drain_b2b: %0d back-to-back frames, required 8", b2b_done - s0);
        end
        check_idle("drain_idle_after");

        // empty mid-stream
        push(8'h3C);
        target += 1;
        n = 0;
        while (frame_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL midstream_frame_done: frame_done=%b after %0d clocks, required 1", frame_done, n);
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || ifc.enable_read !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midstream_gap: %0d bad cycles, required 0", bad);
        end
        push_e0 = cyc + 1;  // count of the first edge that sees the empty flag low
        push(8'hFF);
        target += 1;
        wait_frames(target);
        checks++;
        if (last_start_cyc - push_e0 != 2) begin
            failures++;
            $display("FAIL midstream_latency: %0d clocks, required 2", last_start_cyc - push_e0);
        end

        // reset during data bit 3 of 0x55
        s0 = starts;
        push(8'h55);
        push(8'h0F);
        n = 0;
        while (starts == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (starts == s0) begin
            failures++;
            $display("FAIL rst_mid_start: no start bit after %0d clocks, required one", n);
        end
        repeat (17) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || ifc.enable_read !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs: tx=%b busy=%b er=%b fd=%b, required 1 0 0 0",
                     tx, busy, ifc.enable_read, frame_done);
        end
        p0 = pops;
        repeat (4) @(negedge clk);
        checks++;
        if (pops != p0) begin
            failures++;
            $display("FAIL rst_mid_pops: %0d pops during reset, required 0", pops - p0);
        end
        rst = 1'b1;
        target += 2;
        wait_frames(target);

        // empty flag rises during POP
        p0 = pops;
        push(8'h96);
        push(8'h69);
        n = 0;
        while (ifc.enable_read !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ifc.enable_read !== 1'b1) begin
            failures++;
            $display("FAIL glitch_pop: enable_read=%b, required 1", ifc.enable_read);
        end
        @(posedge clk);
        #1 force_empty = 1'b1;
        repeat (5) @(negedge clk);
        force_empty = 1'b0;
        target += 2;
        wait_frames(target);
        checks++;
        if (pops - p0 != 2) begin
            failures++;
            $display("FAIL glitch_pops: %0d pops, required 2", pops - p0);
        end

        // random words with random spacing
        for (int i = 0; i < 12; i++) begin
            rv = BD'($urandom);
            push(rv);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        target += 12;
        wait_frames(target);
        check_idle("random_idle_after");

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL outstanding: %0d words never framed, required 0", exp_q.size());
        end
        checks++;
        if (pops != pushed) begin
            failures++;
            $display("FAIL total_pops: %0d pops, required %0d", pops, pushed);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
